stopwatch_bcd: RTL and testbench
================================

# stopwatch_bcd

Stopwatch core between `clockDivider` and the `sevenSeg` decoders: consumes the divided 10 Hz tick and two raw pushbuttons, and produces four BCD digits (M:SS.t) for the display stage. Contains the button synchronisers, debouncers and the run/pause/idle state machine, so the decoders need only combinational mapping. Replaces the free-running `counter` stage when the board runs in stopwatch mode.

## Interface
- `DEBOUNCE_CYCLES`, 100000: consecutive stable clocks (10 ms at 10 MHz) before a key change is accepted; minimum 2.
- `MAX_MINUTES`, 9: highest minutes value before wrap; range 0–9.

- `clock`  in  1  system clock (ADC_CLK_10 domain).
- `reset`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-`clock`-wide enable pulse at 10 Hz from `clockDivider`.
- `key_start_n`  in  1  raw start/stop pushbutton, active low, asynchronous.
- `key_lap_n`  in  1  raw lap/clear pushbutton, active low, asynchronous.
- `digit0`  out  4  tenths of seconds, 0–9.
- `digit1`  out  4  seconds units, 0–9.
- `digit2`  out  4  seconds tens, 0–5.
- `digit3`  out  4  minutes, 0–`MAX_MINUTES`.
- `running`  out  1  high in RUN state.
- `lap_hold`  out  1  high while display is frozen on a lap snapshot.
- `wrapped`  out  1  one-cycle pulse when the count wraps to 0:00.0.

## Operation
- Each key: 2-flop synchroniser -> debouncer. Debouncer holds `stable` (reset 1); counter clears whenever synced value equals `stable`, else increments; on reaching `DEBOUNCE_CYCLES` `stable` takes the synced value and counter clears. Press event = one-cycle pulse on `stable` 1->0. Releases generate no event. Glitches shorter than `DEBOUNCE_CYCLES` produce nothing.
- FSM states IDLE, RUN, PAUSE; reset -> IDLE.
  - IDLE: start -> RUN. Lap ignored.
  - RUN: start -> PAUSE. Lap toggles `lap_hold`.
  - PAUSE: start -> RUN. Lap: if `lap_hold`=1, clear `lap_hold`, stay PAUSE; else clear count to 0:00.0, -> IDLE.
  - Start and lap events in the same cycle: start acts, lap dropped.
- Counting: count advances by 0.1 s on each cycle where state is RUN and `tick`=1 (current-state, registered). Cascade tenths 9->0 carries to units, units 9->0 to tens, tens 5->0 to minutes. At `MAX_MINUTES`:59.9 the next tick gives 0:00.0, pulses `wrapped`, stays RUN.
- Lap snapshot: on the cycle `lap_hold` goes 0->1, snapshot registers load the live count as it stands in that cycle (pre-increment). Live count keeps running.
- Digits = snapshot when `lap_hold`=1, else live count (mux of registered values).

## Timing
- Reset (sampled on `clock` edge): all digits 0, `running`=0, `lap_hold`=0, `wrapped`=0, debouncer `stable`=1, counters 0, state IDLE. Reset mid-count or mid-debounce discards all state; a key still held after reset is not re-reported until released and pressed again.
- Key-to-state latency: state changes exactly `DEBOUNCE_CYCLES`+3 clock edges after the first edge sampling the key low (key held).
- Tick in the same cycle as IDLE/PAUSE->RUN: not counted. Tick in the same cycle as RUN->PAUSE: counted.
- `wrapped` asserts on the same edge the digits become 0:00.0.

## Configuration
- `STOPWATCH_LAP_EN` defined: lap/snapshot behaviour as above.
- Undefined: no snapshot registers; `lap_hold` tied 0; lap in RUN ignored; lap in PAUSE clears count -> IDLE; digits always show live count.

## Test plan
- `DEBOUNCE_CYCLES`=4: hold `key_start_n` low 20 cycles -> `running`=1 exactly 7 edges after first low sample; 25 ticks -> digits 0:02.5.
- Bounce `key_start_n` low 3 cycles, high 3 cycles, repeated 5 times -> no event, state stays IDLE, digits 0:00.0.
- `MAX_MINUTES`=1, run from 1:59.8 -> two ticks give 1:59.9 then 0:00.0 with `wrapped` high one cycle, `running` still 1.
- RUN at 0:03.4, lap press -> `lap_hold`=1, digits stay 0:03.4 while 10 ticks pass; second lap -> digits 0:04.4 (live).
- RUN, press start -> PAUSE, lap -> digits 0:00.0, IDLE; start and lap pressed in same cycle from IDLE -> RUN, `lap_hold`=0.
- Assert `reset` one cycle at 0:45.6 with `lap_hold`=1 -> next cycle all outputs 0, IDLE.

Source files
------------

// File: rtl/stopwatch_bcd.sv
// M:SS.t stopwatch core: key synchronisers, debouncers, IDLE/RUN/PAUSE control and BCD count.
// Lap snapshot support is compiled in only when STOPWATCH_LAP_EN is defined.
module stopwatch_bcd #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int MAX_MINUTES     = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       key_start_n,
    input  logic       key_lap_n,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic       running,
    output logic       lap_hold,
    output logic       wrapped
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    armed;
    logic [1:0]    stable;
    logic [1:0]    press;
    logic [CW-1:0] cnt [2];

    logic start_ev;
    logic lap_ev;

    state_t state;
    state_t state_next;
    logic   clear_count;
    logic   advance;
    logic   at_max;

    logic [3:0] tenths;
    logic [3:0] units;
    logic [3:0] tens;
    logic [3:0] minutes;

    assign raw      = {key_lap_n, key_start_n};
    assign start_ev = press[0];
    assign lap_ev   = press[1];

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // A key is armed only once it has been seen released, so a key held through reset stays silent.
    always_ff @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                armed[k]  <= 1'b0;
                stable[k] <= 1'b1;
                cnt[k]    <= '0;
                press[k]  <= 1'b0;
            end else begin
                press[k] <= 1'b0;
                if (!armed[k]) begin
                    armed[k] <= sync2[k];
                    cnt[k]   <= '0;
                end else if (sync2[k] == stable[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable[k] <= sync2[k];
                    cnt[k]    <= '0;
                    press[k]  <= stable[k];
                end else begin
                    cnt[k] <= cnt[k] + CW'(1);
                end
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic       lap_q;
    logic       lap_next;
    logic       snap_load;
    logic [3:0] snap0;
    logic [3:0] snap1;
    logic [3:0] snap2;
    logic [3:0] snap3;
    assign lap_hold = lap_q;
`else
    assign lap_hold = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
`ifdef STOPWATCH_LAP_EN
            lap_q <= 1'b0;
`endif
        end else begin
            state <= state_next;
`ifdef STOPWATCH_LAP_EN
            lap_q <= lap_next;
`endif
        end
    end

    // Start always wins over a simultaneous lap event.
    always_comb begin
        state_next  = state;
        clear_count = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap_next    = lap_q;
        snap_load   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start_ev) state_next = RUN;
            end
            RUN: begin
                if (start_ev) begin
                    state_next = PAUSE;
                end
`ifdef STOPWATCH_LAP_EN
                else if (lap_ev) begin
                    lap_next  = ~lap_q;
                    snap_load = ~lap_q;
                end
`endif
            end
            PAUSE: begin
                if (start_ev) begin
                    state_next = RUN;
                end else if (lap_ev) begin
`ifdef STOPWATCH_LAP_EN
                    if (lap_q) begin
                        lap_next = 1'b0;
                    end else begin
                        clear_count = 1'b1;
                        state_next  = IDLE;
                    end
`else
                    clear_count = 1'b1;
                    state_next  = IDLE;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign running = (state == RUN);
    assign advance = (state == RUN) && tick;
    assign at_max  = (minutes == 4'(MAX_MINUTES)) && (tens == 4'd5) &&
                     (units == 4'd9) && (tenths == 4'd9);

    always_ff @(posedge clock) begin
        if (reset) begin
            tenths  <= '0;
            units   <= '0;
            tens    <= '0;
            minutes <= '0;
            wrapped <= 1'b0;
        end else begin
            wrapped <= 1'b0;
            if (clear_count) begin
                tenths  <= '0;
                units   <= '0;
                tens    <= '0;
                minutes <= '0;
            end else if (advance) begin
                wrapped <= at_max;
                if (tenths != 4'd9) begin
                    tenths <= tenths + 4'd1;
                end else begin
                    tenths <= '0;
                    if (units != 4'd9) begin
                        units <= units + 4'd1;
                    end else begin
                        units <= '0;
                        if (tens != 4'd5) begin
                            tens <= tens + 4'd1;
                        end else begin
                            tens <= '0;
                            minutes <= (minutes == 4'(MAX_MINUTES)) ? 4'd0 : minutes + 4'd1;
                        end
                    end
                end
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    // Snapshot captures the count as it stood before this cycle's increment.
    always_ff @(posedge clock) begin
        if (reset) begin
            snap0 <= '0;
            snap1 <= '0;
            snap2 <= '0;
            snap3 <= '0;
        end else if (snap_load) begin
            snap0 <= tenths;
            snap1 <= units;
            snap2 <= tens;
            snap3 <= minutes;
        end
    end

    assign digit0 = lap_q ? snap0 : tenths;
    assign digit1 = lap_q ? snap1 : units;
    assign digit2 = lap_q ? snap2 : tens;
    assign digit3 = lap_q ? snap3 : minutes;
`else
    assign digit0 = tenths;
    assign digit1 = units;
    assign digit2 = tens;
    assign digit3 = minutes;
`endif
endmodule

// File: tb/tb_stopwatch_bcd.sv
// Scoreboarded bench for stopwatch_bcd: a tenths-count reference model predicts every cycle's outputs.
// Honours STOPWATCH_LAP_EN the same way as the design.
module tb_stopwatch_bcd;
    localparam int D     = 4;
    localparam int MAXM  = 1;
    localparam int TOTAL = (MAXM + 1) * 600;

    typedef struct packed {
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
        logic       run;
        logic       hold;
        logic       wrap;
    } out_t;

    logic       clock;
    logic       reset;
    logic       tick;
    logic       key_start_n;
    logic       key_lap_n;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic       running;
    logic       lap_hold;
    logic       wrapped;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    out_t exp_q[$];

    stopwatch_bcd #(.DEBOUNCE_CYCLES(D), .MAX_MINUTES(MAXM)) dut (
        .clock(clock), .reset(reset), .tick(tick),
        .key_start_n(key_start_n), .key_lap_n(key_lap_n),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .running(running), .lap_hold(lap_hold), .wrapped(wrapped)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model state: count held as plain tenths of a second.
    int m_state;
    int run_len [2];
    bit s1 [2];
    bit s2 [2];
    bit armed [2];
    bit stable [2];
    bit ev [2];
    int count;
    int snap;
    bit hold;
    bit wrap;

    function automatic out_t make_out(int c, bit r, bit h, bit w);
        out_t o;
        o.d0   = 4'(c % 10);
        o.d1   = 4'((c / 10) % 10);
        o.d2   = 4'((c / 100) % 6);
        o.d3   = 4'(c / 600);
        o.run  = r;
        o.hold = h;
        o.wrap = w;
        return o;
    endfunction

    task automatic model_step();
        bit raw [2];
        bit start;
        bit lap;
        bit do_clear;
        int new_state;
        raw[0] = key_start_n;
        raw[1] = key_lap_n;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                s1[k] = 0; s2[k] = 0; armed[k] = 0; stable[k] = 1; ev[k] = 0; run_len[k] = 0;
            end
            m_state = 0; count = 0; snap = 0; hold = 0; wrap = 0;
        end else begin
            start = ev[0];
            lap   = ev[1];
            for (int k = 0; k < 2; k++) begin
                ev[k] = 0;
                if (!armed[k]) begin
                    armed[k] = s2[k];
                    run_len[k] = 0;
                end else if (s2[k] == stable[k]) begin
                    run_len[k] = 0;
                end else begin
                    run_len[k]++;
                    if (run_len[k] == D) begin
                        ev[k] = stable[k];
                        stable[k] = s2[k];
                        run_len[k] = 0;
                    end
                end
                s2[k] = s1[k];
                s1[k] = raw[k];
            end
            do_clear  = 0;
            new_state = m_state;
            if (start) begin
                new_state = (m_state == 1) ? 2 : 1;
            end else if (lap) begin
                if (m_state == 1) begin
`ifdef STOPWATCH_LAP_EN
                    if (!hold) snap = count;
                    hold = !hold;
`endif
                end else if (m_state == 2) begin
`ifdef STOPWATCH_LAP_EN
                    if (hold) hold = 0;
                    else begin do_clear = 1; new_state = 0; end
`else
                    do_clear = 1; new_state = 0;
`endif
                end
            end
            wrap = (m_state == 1) && tick && (count == TOTAL - 1);
            if (do_clear) count = 0;
            else if (m_state == 1 && tick) count = (count + 1) % TOTAL;
            m_state = new_state;
        end
        exp_q.push_back(make_out(hold ? snap : count, m_state == 1, hold, wrap));
    endtask

    initial begin
        forever begin
            @(posedge clock);
            model_step();
        end
    end

    function automatic out_t dut_out();
        out_t o;
        o.d3 = digit3; o.d2 = digit2; o.d1 = digit1; o.d0 = digit0;
        o.run = running; o.hold = lap_hold; o.wrap = wrapped;
        return o;
    endfunction

    // Monitor: pops one prediction per edge and compares it with the DUT just after the edge.
    initial begin
        out_t e;
        out_t a;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            total++;
            a = dut_out();
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL scoreboard_underflow cycle %0d: got %h, no prediction", cyc, a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    bad++;
                    $display("[TB] FAIL cycle_%0d outputs: got %0d:%0d%0d.%0d run=%b hold=%b wrap=%b want %0d:%0d%0d.%0d run=%b hold=%b wrap=%b",
                             cyc, a.d3, a.d2, a.d1, a.d0, a.run, a.hold, a.wrap,
                             e.d3, e.d2, e.d1, e.d0, e.run, e.hold, e.wrap);
                end
            end
        end
    end

    task automatic check_output(string name, int c, bit r, bit h, bit w);
        out_t e;
        out_t a;
        e = make_out(c, r, h, w);
        a = dut_out();
        total++;
        if (a !== e) begin
            bad++;
            $display("[TB] FAIL %s: got %0d:%0d%0d.%0d run=%b hold=%b wrap=%b want %0d:%0d%0d.%0d run=%b hold=%b wrap=%b",
                     name, a.d3, a.d2, a.d1, a.d0, a.run, a.hold, a.wrap,
                     e.d3, e.d2, e.d1, e.d0, e.run, e.hold, e.wrap);
        end
    endtask

    task automatic idle_cycles(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic tick_pulses(int n);
        repeat (n) begin
            tick = 1'b1;
            @(negedge clock);
            tick = 1'b0;
            @(negedge clock);
        end
    endtask

    task automatic press_key(bit use_start, bit use_lap);
        if (use_start) key_start_n = 1'b0;
        if (use_lap)   key_lap_n   = 1'b0;
        idle_cycles(D + 6);
        key_start_n = 1'b1;
        key_lap_n   = 1'b1;
        idle_cycles(D + 6);
    endtask

    task automatic apply_stimulus(int cycles);
        int hs = 0;
        int hl = 0;
        repeat (cycles) begin
            if (hs == 0 && $urandom_range(0, 99) < 3) hs = $urandom_range(1, 12);
            if (hl == 0 && $urandom_range(0, 99) < 3) hl = $urandom_range(1, 12);
            key_start_n = (hs == 0);
            key_lap_n   = (hl == 0);
            if (hs > 0) hs--;
            if (hl > 0) hl--;
            tick  = ($urandom_range(0, 99) < 30);
            reset = ($urandom_range(0, 399) == 0);
            @(negedge clock);
        end
        reset = 1'b0;
        tick  = 1'b0;
        key_start_n = 1'b1;
        key_lap_n   = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        tick = 1'b0;
        key_start_n = 1'b1;
        key_lap_n = 1'b1;
        idle_cycles(3);
        check_output("reset_state", 0, 0, 0, 0);
        reset = 1'b0;
        idle_cycles(6);

        for (int i = 0; i < 5; i++) begin
            key_start_n = 1'b0;
            idle_cycles(3);
            key_start_n = 1'b1;
            idle_cycles(3);
        end
        idle_cycles(8);
        check_output("bounce_ignored", 0, 0, 0, 0);

        key_start_n = 1'b0;
        idle_cycles(D + 2);
        check_output("start_latency_minus1", 0, 0, 0, 0);
        idle_cycles(1);
        check_output("start_latency_exact", 0, 1, 0, 0);
        idle_cycles(20 - (D + 3));
        key_start_n = 1'b1;
        idle_cycles(D + 6);
        tick_pulses(25);
        check_output("count_0_02_5", 25, 1, 0, 0);

        tick_pulses(TOTAL - 2 - 25);
        check_output("pre_wrap_1_59_8", TOTAL - 2, 1, 0, 0);
        tick_pulses(1);
        check_output("pre_wrap_1_59_9", TOTAL - 1, 1, 0, 0);
        tick = 1'b1;
        @(negedge clock);
        tick = 1'b0;
        check_output("wrap_pulse", 0, 1, 0, 1);
        @(negedge clock);
        check_output("wrap_one_cycle", 0, 1, 0, 0);

        tick_pulses(34);
        press_key(0, 1);
        tick_pulses(10);
`ifdef STOPWATCH_LAP_EN
        check_output("lap_frozen", 34, 1, 1, 0);
`else
        check_output("lap_ignored", 44, 1, 0, 0);
`endif
        press_key(0, 1);
        check_output("lap_release_live", 44, 1, 0, 0);

        press_key(1, 0);
        check_output("paused", 44, 0, 0, 0);
        press_key(0, 1);
        check_output("pause_clear_idle", 0, 0, 0, 0);
        press_key(1, 1);
        check_output("start_beats_lap", 0, 1, 0, 0);

        tick_pulses(456);
        press_key(0, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_output("reset_mid_count", 0, 0, 0, 0);
        idle_cycles(D + 6);

        key_start_n = 1'b0;
        idle_cycles(D + 6);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        idle_cycles(20);
        check_output("held_through_reset", 0, 0, 0, 0);
        key_start_n = 1'b1;
        idle_cycles(D + 6);
        check_output("held_release_silent", 0, 0, 0, 0);
        press_key(1, 0);
        check_output("repress_after_reset", 0, 1, 0, 0);

        apply_stimulus(4000);
        idle_cycles(3 * D + 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
